cal_syndrome_stream: RTL
========================

// Module: cal_syndrome_stream
// PURPOSE
//  Streaming multi-syndrome calculator for the binary BCH decoder over GF(2^M).
//  Accepts a received codeword in PARAM_W-bit beats and computes S_1..S_NSYN in parallel
//  (S_j = sum r_i*alpha^(i*j)), one beat per cycle, by Horner accumulation.
//  Successor to the single-syndrome, whole-vector calculator.
//  Feeds the key-equation solver and flags error-free codewords.
// PARAMETERS
//  PARAM_M         9       field degree m
//  PARAM_POLY      9'h011  primitive polynomial, low m bits (x^9+x^4+1)
//  PARAM_ECC_BITS  160     codeword length N
//  PARAM_W         8       codeword bits per input beat
//  PARAM_NSYN      8       number of syndromes (2t), j = 1..NSYN
//  PARAM_EVEN_SQ   1       1: S_2j = S_j^2 (squarer); 0: every lane uses Horner
//  localparam NBEAT = ceil(N/W); CW = $clog2(NBEAT+1)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  in_valid   in   1        beat valid
//  in_ready   out  1        block accepts beat
//  in_data    in   W        beat; bit k of beat c = codeword position (NBEAT-1-c)*W+k
//  syn_valid  out  1        syndromes available
//  syn_ready  in   1        consumer takes syndromes
//  syn_out    out  NSYN*M   S_j at [(j-1)*M +: M]
//  syn_zero   out  1        all syndromes zero (valid with syn_valid)
//  beat_cnt   out  CW       beats accepted in current frame (debug)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, accumulators 0, beat_cnt 0, syn_valid 0,
//    syn_out 0, syn_zero 0, in_ready 0 while asserted, 1 on the first clk after release.
//  - FSM IDLE -> ACC on the first accepted beat. ACC -> DONE when beat NBEAT is accepted.
//    DONE -> IDLE when syn_valid && syn_ready.
//  - Beat accepted iff in_valid && in_ready. in_ready = (state != DONE).
//    A beat offered in IDLE is beat 1. Gaps (in_valid=0) stall without state change.
//  - Per accepted beat, Horner lane j: acc_j <= acc_j*alpha^(jW) + XOR_k(d_k*alpha^(jk)).
//    In beat 1, d_k is masked to 0 for positions >= N (leading pad bits are ignored).
//    All constant multipliers are elaboration-time constants; no runtime tables.
//  - First accepted beat: acc_j uses 0 as prior value, so frames need no clear cycle.
//  - With EVEN_SQ=1, only odd-j lanes get Horner; even j is computed combinationally as
//    S_2j = S_j^2 (mod PARAM_POLY), with no extra latency.
//  - Latency: syn_valid rises on the clk edge that accepts beat NBEAT, i.e. it is visible
//    the cycle after the last beat. Minimum frame = NBEAT cycles; throughput is 1 frame
//    per NBEAT+1 cycles with syn_ready tied high.
//  - syn_out/syn_zero are held stable while syn_valid && !syn_ready. No beat is accepted in DONE.
//  - Simultaneous DONE handshake and in_valid: the beat is not accepted in that cycle;
//    it is accepted next cycle as beat 1.
//  - Reset mid-frame discards the partial frame; no syn_valid is produced for it.
//  - All GF arithmetic is XOR/AND only. Reduction is by PARAM_POLY, width M at every lane output.
// STRUCTURE
//  - Package pq_syndrome_pkg: gf_mul(a,b,poly,m) and gf_sq functions, gf_alpha_pow(e)
//    constant function, syn_state_t enum {IDLE, ACC, DONE}.
//  - Sub-module syn_horner_lane #(M,POLY,W,J): one accumulator plus constant-multiply XOR tree.
//    Instantiated by generate for each computed j. The top holds the FSM, counter, mask,
//    squarers and the syn_zero reduction.
// TESTING (M=9, POLY=9'h011, N=160, W=8, NSYN=8, EVEN_SQ=1 unless stated)
//  1 all-zero codeword, 20 back-to-back beats -> syn_out=0, syn_zero=1,
//    syn_valid the cycle after beat 20.
//  2 only position 0 set (beat 20 = 8'h01) -> every S_j = 9'h001, syn_zero=0.
//  3 only position 1 set -> S_1..S_8 = 9'h002,004,008,010,020,040,080,100.
//    Only position 9 set -> S_1 = 9'h011.
//  4 random codewords, random in_valid gaps and syn_ready stalls of 0-5 cycles ->
//    syn_out matches the software model. Outputs are stable while stalled.
//    No beat is accepted in DONE.
//  5 rst pulsed low after beat 7, then a new full frame ->
//    all outputs 0 during reset, and only the new frame's syndromes are reported.
//  6 rerun 2-4 with EVEN_SQ=0, W=16 (NBEAT=10) and N=171, W=8 (NBEAT=22, 5 masked pad bits
//    set to 1) -> identical to the model, pad bits have no effect.

Source files
------------

// File: rtl/pq_syndrome_pkg.sv
// Shared GF(2^m) helpers and FSM encoding for the streaming BCH syndrome
// calculator. Arithmetic helpers work on 16-bit containers with a runtime
// field degree m (m <= 16). Every call site passes an elaboration-time m,
// so loops unroll into plain XOR/AND networks.
package pq_syndrome_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } syn_state_t;

  // Multiply by x, then reduce modulo the primitive polynomial (low m bits).
  function automatic logic [15:0] gf_xtime(input logic [15:0] a,
                                           input logic [15:0] poly,
                                           input int m);
    logic [15:0] mask;
    logic        msb;
    logic [15:0] r;
    mask = (16'd1 << m) - 16'd1;
    msb  = a[m-1];
    r    = (a << 1) & mask;
    if (msb) r = r ^ (poly & mask);
    return r;
  endfunction

  // Shift-and-add multiply, MSB of b first.
  function automatic logic [15:0] gf_mul(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] poly,
                                         input int m);
    logic [15:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i < m) begin
        r = gf_xtime(r, poly, m);
        if (b[i]) r = r ^ a;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] gf_sq(input logic [15:0] a,
                                        input logic [15:0] poly,
                                        input int m);
    return gf_mul(a, a, poly, m);
  endfunction

  // alpha^e, with alpha = x. The exponent is reduced mod 2^m-1 first.
  function automatic logic [15:0] gf_alpha_pow(input int e,
                                               input logic [15:0] poly,
                                               input int m);
    int          ord;
    int          ee;
    logic [15:0] r;
    ord = (1 << m) - 1;
    ee  = e % ord;
    r   = 16'd1;
    for (int i = 0; i < ee; i++) r = gf_xtime(r, poly, m);
    return r;
  endfunction

  // j = odd_part(j) * 2^sq_count(j)
  function automatic int odd_part(input int j);
    int v;
    v = j;
    for (int i = 0; i < 16; i++) if ((v > 0) && (v % 2 == 0)) v = v / 2;
    return v;
  endfunction

  function automatic int sq_count(input int j);
    int v;
    int n;
    v = j;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if ((v > 0) && (v % 2 == 0)) begin
        v = v / 2;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/syn_horner_lane.sv
// One Horner accumulator for syndrome S_J over GF(2^M).
// Per enabled beat: acc <= acc*alpha^(J*W) ^ XOR_k(data[k]*alpha^(J*k)).
// On the first beat of a frame the prior value is taken as zero, so no
// clear cycle is needed between frames.
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active-low
//   en_i     accumulate this cycle (beat accepted)
//   first_i  beat is the first of its frame
//   data_i   W beat bits, bit k weighted by alpha^(J*k)
//   acc_o    current accumulator value
module syn_horner_lane
  import pq_syndrome_pkg::*;
#(
  parameter int             M    = 9,
  parameter logic [M-1:0]   POLY = 9'h011,
  parameter int             W    = 8,
  parameter int             J    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         first_i,
  input  logic [W-1:0] data_i,
  output logic [M-1:0] acc_o
);

  localparam logic [M-1:0] STEP = M'(gf_alpha_pow(J * W, 16'(POLY), M));

  logic [M-1:0] acc_q;
  logic [M-1:0] acc_d;
  logic [M-1:0] term [W];
  logic [M-1:0] beat_sum;
  logic [M-1:0] prior;

  // Each beat bit selects a fixed field constant; the sum is a pure XOR tree.
  for (genvar k = 0; k < W; k++) begin : g_term
    localparam logic [M-1:0] CK = M'(gf_alpha_pow(J * k, 16'(POLY), M));
    assign term[k] = data_i[k] ? CK : '0;
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < W; k++) beat_sum = beat_sum ^ term[k];
    prior = first_i ? '0 : M'(gf_mul(16'(acc_q), 16'(STEP), 16'(POLY), M));
    acc_d = prior ^ beat_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cal_syndrome_stream.sv
// Streaming multi-syndrome calculator for a binary BCH decoder over GF(2^M).
// Takes a codeword as NBEAT beats of W bits (first beat carries the highest
// positions) and produces S_1..S_NSYN, one beat per cycle by Horner steps.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   in_valid   beat valid          in_ready  beat can be accepted
//   in_data    beat; bit k of beat c = position (NBEAT-1-c)*W+k
//   syn_valid  syndromes available syn_ready consumer takes them
//   syn_out    S_j at [(j-1)*M +: M]
//   syn_zero   all syndromes zero, qualified by syn_valid
//   beat_cnt   beats accepted in the current frame (debug)
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid-side data is held stable until that edge.
module cal_syndrome_stream
  import pq_syndrome_pkg::*;
#(
  parameter int                   PARAM_M        = 9,
  parameter logic [PARAM_M-1:0]   PARAM_POLY     = 9'h011,
  parameter int                   PARAM_ECC_BITS = 160,
  parameter int                   PARAM_W        = 8,
  parameter int                   PARAM_NSYN     = 8,
  parameter int                   PARAM_EVEN_SQ  = 1,
  localparam int                  NBEAT = (PARAM_ECC_BITS + PARAM_W - 1) / PARAM_W,
  localparam int                  CW    = $clog2(NBEAT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PARAM_W-1:0]            in_data,
  output logic                          syn_valid,
  input  logic                          syn_ready,
  output logic [PARAM_NSYN*PARAM_M-1:0] syn_out,
  output logic                          syn_zero,
  output logic [CW-1:0]                 beat_cnt
);

  // Number of real codeword bits in the first beat; the rest are leading pad.
  localparam int                 HEAD      = PARAM_ECC_BITS - (NBEAT - 1) * PARAM_W;
  localparam logic [PARAM_W-1:0] HEAD_MASK = {PARAM_W{1'b1}} >> (PARAM_W - HEAD);
  localparam int NLANE = (PARAM_EVEN_SQ != 0) ? (PARAM_NSYN + 1) / 2 : PARAM_NSYN;

  syn_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_next;
  logic          rdy_q;
  logic          accept;
  logic          first;
  logic          last;
  logic [PARAM_W-1:0] data_m;

  assign accept   = in_valid && rdy_q;
  assign first    = (state_q == IDLE);
  assign cnt_next = (first ? '0 : cnt_q) + CW'(1);
  assign last     = accept && (cnt_next == CW'(NBEAT));
  assign data_m   = first ? (in_data & HEAD_MASK) : in_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          cnt_d   = cnt_next;
          state_d = last ? DONE : ACC;
        end
      end
      DONE: begin
        if (syn_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // in_ready is registered from the next state so it is low throughout reset
  // and equals (state != DONE) from the first clock after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d != DONE);
    end
  end

  logic [PARAM_M-1:0] lane_acc [NLANE];

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    localparam int JL = (PARAM_EVEN_SQ != 0) ? 2 * l + 1 : l + 1;
    syn_horner_lane #(
      .M    (PARAM_M),
      .POLY (PARAM_POLY),
      .W    (PARAM_W),
      .J    (JL)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (accept),
      .first_i (first),
      .data_i  (data_m),
      .acc_o   (lane_acc[l])
    );
  end

  // Even syndromes come from their odd base by repeated squaring,
  // S_(o*2^s) = S_o^(2^s), so every output reads only lane registers.
  logic [PARAM_M-1:0] syn_w [PARAM_NSYN];

  for (genvar j = 1; j <= PARAM_NSYN; j++) begin : g_syn
    localparam int OJ  = (PARAM_EVEN_SQ != 0) ? odd_part(j) : j;
    localparam int NSQ = (PARAM_EVEN_SQ != 0) ? sq_count(j) : 0;
    localparam int LI  = (PARAM_EVEN_SQ != 0) ? (OJ - 1) / 2 : j - 1;
    logic [PARAM_M-1:0] v;
    always_comb begin
      v = lane_acc[LI];
      for (int s = 0; s < NSQ; s++) v = PARAM_M'(gf_sq(16'(v), 16'(PARAM_POLY), PARAM_M));
    end
    assign syn_w[j-1] = v;
  end

  always_comb begin
    syn_out = '0;
    for (int j = 0; j < PARAM_NSYN; j++) syn_out[j*PARAM_M +: PARAM_M] = syn_w[j];
  end

  assign in_ready  = rdy_q;
  assign syn_valid = (state_q == DONE);
  assign syn_zero  = syn_valid && (syn_out == '0);
  assign beat_cnt  = cnt_q;

endmodule
